// File: rtl/bus_xcvr_sequencer.sv
// Sequences direction, output enable and A-side drive of an 8-bit bus transceiver.
// Optional back-to-back same-direction transfers: define BUS_XCVR_B2B_EN.
module bus_xcvr_sequencer #(
  parameter int TURN_CYCLES   = 2,
  parameter int ACTIVE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       DIR,
  output logic       nOE,
  inout  tri   [7:0] A
);

  typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, RELEASE} state_t;

  localparam logic [3:0] TURN_LOAD   = 4'(TURN_CYCLES);
  localparam logic [3:0] ACTIVE_LOAD = 4'(ACTIVE_CYCLES);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       write_q;
  logic [7:0] wdata_q;
  logic       last_cycle;
  logic       accept;
  logic       a_drive;

  assign last_cycle = (cnt == 4'd1);
  assign accept     = req_valid && req_ready;

  // The captured direction is the transceiver direction; it only changes at acceptance.
  assign DIR     = write_q;
  assign nOE     = (state != ACTIVE);
  assign a_drive = (state == ACTIVE) && write_q;
  assign A       = a_drive ? wdata_q : 8'bz;

  always_comb begin
    req_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: req_ready = 1'b1;
`ifdef BUS_XCVR_B2B_EN
        // Opposite-direction requests are refused here so they wait for IDLE.
        ACTIVE: req_ready = last_cycle && (!req_valid || (req_write == write_q));
`endif
        default: req_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
          cnt_nxt   = TURN_LOAD;
        end
      end
      SETUP: begin
        if (last_cycle) begin
          state_nxt = ACTIVE;
          cnt_nxt   = ACTIVE_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ACTIVE: begin
        if (last_cycle) begin
          if (accept) begin
            state_nxt = ACTIVE;
            cnt_nxt   = ACTIVE_LOAD;
          end else begin
            state_nxt = RELEASE;
            cnt_nxt   = TURN_LOAD;
          end
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RELEASE: begin
        if (last_cycle) begin
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      write_q   <= 1'b0;
      wdata_q   <= 8'h00;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      // Completion is the edge leaving the last ACTIVE cycle, whatever comes next.
      rsp_valid <= (state == ACTIVE) && last_cycle;
      if (accept) begin
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
      if ((state == ACTIVE) && last_cycle && !write_q) begin
        rsp_rdata <= A;
      end
    end
  end

endmodule

// File: tb/tb_bus_xcvr_sequencer.sv
// Randomized self-checking bench for bus_xcvr_sequencer against a phase-offset model.
module tb_bus_xcvr_sequencer;

  localparam int T = 2;
  localparam int A = 3;
  localparam int L = 2 * T + A + 1;
`ifdef BUS_XCVR_B2B_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_wdata = 8'h00;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       dir;
  logic       noe;
  tri   [7:0] a_bus;

  // The bench plays the B side (and a keeper) whenever the DUT should not drive A.
  logic       bench_drive = 1'b1;
  logic [7:0] ext_data = 8'h5A;
  assign a_bus = bench_drive ? ext_data : 8'bz;

  int         checks = 0;
  int         errors = 0;
  logic       m_dir = 1'b0;
  logic [7:0] m_rdata = 8'h00;

  always #5 clk = ~clk;

  bus_xcvr_sequencer #(.TURN_CYCLES(T), .ACTIVE_CYCLES(A)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .DIR(dir), .nOE(noe), .A(a_bus)
  );

  task automatic test_reset();
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_ready: got %b want 0", req_ready); end
    checks++; if (noe !== 1'b1) begin errors++; $display("[TB] FAIL rst_noe: got %b want 1", noe); end
    checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL rst_dir: got %b want 0", dir); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("[TB] FAIL rst_rdata: got %h want 00", rsp_rdata); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  // Entered just after a negedge with the DUT idle; returns at the negedge of the cycle back in IDLE.
  task automatic test_transaction(input bit wr, input logic [7:0] data, input logic [7:0] ext);
    logic exp_noe, exp_rv, exp_rdy, drv;
    req_valid = 1'b1;
    req_write = wr;
    req_wdata = data;
    ext_data  = wr ? ~data : ext;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL accept_ready: got %b want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wdata = ~data;
    for (int j = 1; j <= L; j++) begin
      drv = wr && (j > T) && (j <= T + A);
      if (j > 1) begin @(posedge clk); #1; end
      bench_drive = !drv;
      @(negedge clk);
      exp_noe = !((j > T) && (j <= T + A));
      exp_rv  = (j == T + A + 1);
      exp_rdy = (j == L) || (B2B && (j == T + A));
      if (exp_rv && !wr) m_rdata = ext;
      checks++; if (noe !== exp_noe) begin errors++; $display("[TB] FAIL txn_noe j=%0d wr=%0d: got %b want %b", j, wr, noe, exp_noe); end
      checks++; if (dir !== wr) begin errors++; $display("[TB] FAIL txn_dir j=%0d: got %b want %b", j, dir, wr); end
      checks++; if (rsp_valid !== exp_rv) begin errors++; $display("[TB] FAIL txn_rsp_valid j=%0d: got %b want %b", j, rsp_valid, exp_rv); end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("[TB] FAIL txn_ready j=%0d: got %b want %b", j, req_ready, exp_rdy); end
      checks++; if (rsp_rdata !== m_rdata) begin errors++; $display("[TB] FAIL txn_rdata j=%0d: got %h want %h", j, rsp_rdata, m_rdata); end
      checks++; if (a_bus !== (drv ? data : ext_data)) begin errors++; $display("[TB] FAIL txn_a_bus j=%0d wr=%0d: got %h want %h", j, wr, a_bus, drv ? data : ext_data); end
    end
    bench_drive = 1'b1;
    m_dir = wr;
  endtask

  task automatic test_write();
    test_transaction(1'b1, 8'hA5, 8'h00);
  endtask

  task automatic test_read();
    test_transaction(1'b0, 8'h00, 8'h3C);
  endtask

  task automatic test_back_to_back();
    test_transaction(1'b1, 8'($urandom_range(1, 255)), 8'h00);
    test_transaction(1'b0, 8'h00, 8'($urandom));
    test_transaction(1'b1, 8'($urandom_range(1, 255)), 8'h00);
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 12; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_ready: got %b want 1", req_ready); end
        checks++; if (noe !== 1'b1) begin errors++; $display("[TB] FAIL idle_noe: got %b want 1", noe); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (dir !== m_dir) begin errors++; $display("[TB] FAIL idle_dir: got %b want %b", dir, m_dir); end
      end
      test_transaction(1'($urandom_range(0, 1)), 8'($urandom_range(1, 255)), 8'($urandom));
    end
  endtask

  task automatic test_held_valid();
    int acc[$];
    int rsp[$];
    int second = B2B ? T + A : L;
    int last_n = B2B ? 2 * T + 2 * A + 1 : 2 * L;
    int rsp2   = B2B ? T + 2 * A + 1 : L + T + A + 1;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wdata = 8'($urandom_range(1, 255));
    for (int n = 0; n <= last_n; n++) begin
      if (n > 0) @(negedge clk);
      if (req_valid && req_ready) acc.push_back(n);
      if (rsp_valid) rsp.push_back(n);
      if (n < last_n) begin
        @(posedge clk); #1;
        if (n == 0) req_wdata = 8'($urandom_range(1, 255));
        if (n == second) req_valid = 1'b0;
      end
    end
    m_dir = 1'b1;
    checks++;
    if (acc.size() != 2 || acc[0] != 0 || acc[1] != second) begin
      errors++; $display("[TB] FAIL held_accepts: got %0d accepts (2nd at %0d) want 2 (2nd at %0d)", acc.size(), (acc.size() > 1) ? acc[1] : -1, second);
    end
    checks++;
    if (rsp.size() != 2 || rsp[0] != T + A + 1 || rsp[1] != rsp2) begin
      errors++; $display("[TB] FAIL held_rsp: got %0d pulses (at %0d,%0d) want 2 (at %0d,%0d)", rsp.size(), (rsp.size() > 0) ? rsp[0] : -1, (rsp.size() > 1) ? rsp[1] : -1, T + A + 1, rsp2);
    end
  endtask

  task automatic test_reset_mid_txn();
    int pulses = 0;
    int low = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wdata = 8'hA5;
    ext_data  = 8'h5A;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (T) begin @(posedge clk); #1; end
    bench_drive = 1'b0;
    @(posedge clk); #1;
    checks++; if (a_bus !== 8'hA5) begin errors++; $display("[TB] FAIL mid_a_bus: got %h want a5", a_bus); end
    rst = 1'b1;
    bench_drive = 1'b1;
    #1;
    checks++; if (noe !== 1'b1) begin errors++; $display("[TB] FAIL mid_rst_noe: got %b want 1", noe); end
    checks++; if (dir !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_dir: got %b want 0", dir); end
    checks++; if (a_bus !== 8'h5A) begin errors++; $display("[TB] FAIL mid_rst_a_bus: got %h want 5a", a_bus); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ready: got %b want 0", req_ready); end
    checks++; if (rsp_rdata !== 8'h00) begin errors++; $display("[TB] FAIL mid_rst_rdata: got %h want 00", rsp_rdata); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_release_ready: got %b want 1", req_ready); end
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulses++;
      if (noe !== 1'b1) low++;
    end
    checks++; if (pulses != 0) begin errors++; $display("[TB] FAIL mid_no_rsp: got %0d pulses want 0", pulses); end
    checks++; if (low != 0) begin errors++; $display("[TB] FAIL mid_noe_idle: got %0d low cycles want 0", low); end
    m_dir = 1'b0;
    m_rdata = 8'h00;
    test_transaction(1'b1, 8'hC3, 8'h00);
  endtask

`ifdef BUS_XCVR_B2B_EN
  task automatic test_b2b();
    int run = 0;
    int max_run = 0;
    int pulses = 0;
    int accepts = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wdata = 8'h11;
    bench_drive = 1'b0;
    @(posedge clk); #1;
    req_wdata = 8'h22;
    for (int n = 1; n <= 2 * T + 2 * A + 1; n++) begin
      @(negedge clk);
      run = (noe === 1'b0) ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (rsp_valid === 1'b1) pulses++;
      if (req_valid && req_ready) accepts++;
      @(posedge clk); #1;
      if (accepts > 0) req_valid = 1'b0;
    end
    @(negedge clk);
    bench_drive = 1'b1;
    m_dir = 1'b1;
    checks++; if (max_run != 2 * A) begin errors++; $display("[TB] FAIL b2b_noe_run: got %0d want %0d", max_run, 2 * A); end
    checks++; if (pulses != 2) begin errors++; $display("[TB] FAIL b2b_rsp: got %0d want 2", pulses); end
    checks++; if (accepts != 1) begin errors++; $display("[TB] FAIL b2b_accept: got %0d want 1", accepts); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_random();
    test_held_valid();
    test_reset_mid_txn();
`ifdef BUS_XCVR_B2B_EN
    test_b2b();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
